demux_dispatcher: RTL and testbench
===================================

// Module: demux_dispatcher
// PURPOSE
//   Upstream feeder for the 1-to-4 WIDTH-bit lane demux. Accepts words on a
//   valid/ready input and presents each word to the demux as data_out plus a
//   2-bit sel_out. Each word is held for at least MIN_HOLD cycles so board LEDs
//   can show it, then held further until the selected lane acknowledges it.
//   Lanes are chosen round-robin or by manual switch select.
// PARAMETERS
//   WIDTH     8  data word width; must match the demux WIDTH
//   MIN_HOLD  4  minimum cycles a word is presented (>=1)
//   CNT_W     8  width of the completed-transfer counter
// PORTS
//   clk         in   1         system clock, rising edge
//   reset       in   1         asynchronous, active-high reset
//   in_data     in   WIDTH     word to dispatch
//   in_valid    in   1         in_data is valid
//   in_ready    out  1         block can accept a word; high only in IDLE
//   mode        in   1         0 = round-robin lane select, 1 = manual select
//   man_sel     in   2         lane used when mode=1
//   data_out    out  WIDTH     to demux data input
//   sel_out     out  2         to demux sel input
//   lane_valid  out  4         one-hot; word pending on lane sel_out
//   lane_ready  in   4         per-lane acknowledge from downstream
//   busy        out  1         high in HOLD
//   xfer_count  out  CNT_W     number of completed transfers, wraps
// BEHAVIOUR
//   Reset (async, immediate):
//   - State=IDLE; rr_ptr=0; hold_cnt=0.
//   - data_out=0, sel_out=0, lane_valid=0, busy=0, xfer_count=0.
//   FSM, 2 states:
//   - IDLE: in_ready=1, lane_valid=0.
//     - If in_valid at an edge: data_out<=in_data.
//     - sel_out<=(mode ? man_sel : rr_ptr).
//     - hold_cnt<=MIN_HOLD-1; go to HOLD.
//   - HOLD: in_ready=0, busy=1, lane_valid=1<<sel_out.
//     - While hold_cnt!=0, decrement hold_cnt every cycle.
//     - Done condition: hold_cnt==0 && lane_ready[sel_out].
//     - On done: go to IDLE; xfer_count++ (wraps to 0 at 2^CNT_W).
//       If mode was 0 at accept, rr_ptr<=sel_out+1 (mod 4); otherwise rr_ptr is unchanged.
//   Timing:
//   - Word accepted at edge k; lane_valid is high from k.
//   - Earliest completion is at edge k+MIN_HOLD-1+1 = k+MIN_HOLD.
//   - The IDLE cycle follows, so max throughput is 1 word per MIN_HOLD+1 cycles.
//   - MIN_HOLD=1: the word completes on the first HOLD cycle if ready is high.
//   Sampling and hold rules:
//   - mode and man_sel are sampled only at accept; changes during HOLD have no effect.
//   - data_out and sel_out stay stable through HOLD.
//   - data_out and sel_out retain their last value in IDLE (not cleared).
//   - lane_ready is ignored in IDLE and on non-selected lanes.
//   - Backpressure is unbounded: HOLD persists until ack; no timeout.
//   - Manual-mode transfers never move rr_ptr. Returning to mode=0 resumes at the stored rr_ptr.
//   Reset during HOLD:
//   - The word is dropped; no count increment.
//   - All outputs take reset values asynchronously.
// TESTING
//   T1 reset: assert reset mid-run -> data_out=0, sel_out=0, lane_valid=0,
//      busy=0, xfer_count=0, in_ready=1 after release.
//   T2 round-robin: MIN_HOLD=4, lane_ready=4'hF, mode=0; send A1,B2,C3,D4,E5
//      -> sel_out 0,1,2,3,0; lane_valid 0001,0010,0100,1000,0001; each word held
//      exactly 4 cycles; xfer_count=5.
//   T3 backpressure: word 0x5A to lane 1 with lane_ready[1]=0 for 10 cycles
//      -> lane_valid=0010, data_out=5A, in_ready=0 throughout; raise
//      lane_ready[1] -> IDLE next edge, xfer_count+1, rr_ptr=2.
//   T4 manual mode: mode=1, man_sel=2, three words -> all sel_out=2, rr_ptr
//      unchanged; then mode=0 -> next word goes to the prior rr_ptr lane.
//   T5 mid-HOLD changes: toggle man_sel/mode and drive lane_ready on other lanes
//      during HOLD -> sel_out, data_out, completion timing unaffected.
//   T6 wrap: CNT_W=2, 5 transfers -> xfer_count 1,2,3,0,1.

Source files
------------

// File: rtl/demux_dispatcher_if.sv
// Handshake bundle between the word source, the dispatcher and the 1-to-4 lane demux.
// The slave side is the dispatcher; the master side is whoever feeds words in and acknowledges lanes.
interface demux_dispatcher_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [1:0]       man_sel;
    logic [WIDTH-1:0] data_out;
    logic [1:0]       sel_out;
    logic [3:0]       lane_valid;
    logic [3:0]       lane_ready;
    logic             busy;
    logic [CNT_W-1:0] xfer_count;

    modport slave (
        input  in_data, in_valid, mode, man_sel, lane_ready,
        output in_ready, data_out, sel_out, lane_valid, busy, xfer_count
    );

    modport master (
        output in_data, in_valid, mode, man_sel, lane_ready,
        input  in_ready, data_out, sel_out, lane_valid, busy, xfer_count
    );
endinterface

// File: rtl/demux_dispatcher.sv
// Feeds the 1-to-4 lane demux: latches one word, holds it at least MIN_HOLD cycles,
// then waits for the selected lane's acknowledge. Lane is round-robin or switch-selected.
module demux_dispatcher #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MIN_HOLD = 4,
    parameter int unsigned CNT_W    = 8
) (
    input logic               clk,
    input logic               reset,
    demux_dispatcher_if.slave bus
);
    localparam int unsigned HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state, state_nxt;
    logic [HW-1:0]    hold_cnt;
    logic [1:0]       rr_ptr;
    logic [1:0]       sel_q;
    logic             manual_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] count_q;
    logic             accept;
    logic             done;
    logic             in_ready_c;
    logic             busy_c;
    logic [3:0]       lane_valid_c;

    assign accept = (state == IDLE) && bus.in_valid;
    assign done   = (state == HOLD) && (hold_cnt == '0) && bus.lane_ready[sel_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = HOLD;
            HOLD: if (done)   state_nxt = IDLE;
            default:          state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c   = 1'b0;
        busy_c       = 1'b0;
        lane_valid_c = '0;
        unique case (state)
            IDLE: in_ready_c = 1'b1;
            HOLD: begin
                busy_c       = 1'b1;
                lane_valid_c = 4'b0001 << sel_q;
            end
            default: in_ready_c = 1'b0;
        endcase
    end

    // mode is captured at accept so switch changes during HOLD cannot move rr_ptr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= '0;
            sel_q    <= '0;
            manual_q <= 1'b0;
            hold_cnt <= '0;
            rr_ptr   <= '0;
            count_q  <= '0;
        end else if (accept) begin
            data_q   <= bus.in_data;
            sel_q    <= bus.mode ? bus.man_sel : rr_ptr;
            manual_q <= bus.mode;
            hold_cnt <= HW'(MIN_HOLD - 1);
        end else if (state == HOLD) begin
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
            if (done) begin
                count_q <= count_q + CNT_W'(1);
                if (!manual_q) begin
                    rr_ptr <= sel_q + 2'd1;
                end
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.busy       = busy_c;
    assign bus.lane_valid = lane_valid_c;
    assign bus.data_out   = data_q;
    assign bus.sel_out    = sel_q;
    assign bus.xfer_count = count_q;
endmodule

// File: tb/tb_demux_dispatcher.sv
// Scoreboard bench for demux_dispatcher: a driver pushes expected words as they are accepted,
// a negedge monitor pops them and checks lane, data, hold length, retention and count wrap.
module tb_demux_dispatcher;
    localparam int unsigned MIN_HOLD = 4;
    localparam int unsigned CNT_W    = 2;

    typedef struct {
        logic [7:0] data;
        logic [1:0] sel;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    exp_t       q[$];
    logic [1:0] rr_m = 2'd0;
    int         rdy_mode = 1;
    logic [3:0] rdy_force = 4'hF;

    logic       mon_active = 1'b0;
    logic       done_exp = 1'b0;
    int         hold_n = 0;
    exp_t       cur;
    logic [1:0] cnt_m = 2'd0;
    logic [7:0] last_data = 8'h00;
    logic [1:0] last_sel = 2'd0;

    demux_dispatcher_if #(.WIDTH(8), .CNT_W(CNT_W)) bus ();

    demux_dispatcher #(.WIDTH(8), .MIN_HOLD(MIN_HOLD), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.lane_ready = 4'($urandom_range(0, 15));
            1:       bus.lane_ready = 4'hF;
            default: bus.lane_ready = rdy_force;
        endcase
    end

    // Reference: a word completes on the first HOLD cycle n >= MIN_HOLD whose selected lane is ready
    always @(negedge clk) begin
        if (reset) begin
            mon_active = 1'b0;
            done_exp   = 1'b0;
            cnt_m      = 2'd0;
            last_data  = 8'h00;
            last_sel   = 2'd0;
        end else if (mon_active && done_exp) begin
            chk("done_busy", 32'(bus.busy), 32'd0);
            chk("done_lane_valid", 32'(bus.lane_valid), 32'd0);
            chk("done_in_ready", 32'(bus.in_ready), 32'd1);
            chk("done_count", 32'(bus.xfer_count), 32'(cnt_m));
            chk("retain_data", 32'(bus.data_out), 32'(last_data));
            chk("retain_sel", 32'(bus.sel_out), 32'(last_sel));
            mon_active = 1'b0;
            done_exp   = 1'b0;
        end else if (mon_active || bus.busy) begin
            if (!mon_active) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 32'(bus.busy), 32'd0);
                    cur = '{data: bus.data_out, sel: bus.sel_out};
                end else begin
                    cur = q.pop_front();
                end
                mon_active = 1'b1;
                hold_n     = 0;
                last_data  = cur.data;
                last_sel   = cur.sel;
            end
            chk("hold_busy", 32'(bus.busy), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_data", 32'(bus.data_out), 32'(cur.data));
            chk("hold_sel", 32'(bus.sel_out), 32'(cur.sel));
            chk("hold_lane_valid", 32'(bus.lane_valid), 32'(4'b0001 << cur.sel));
            hold_n++;
            done_exp = (hold_n >= int'(MIN_HOLD)) && bus.lane_ready[cur.sel];
            if (done_exp) cnt_m = cnt_m + 2'd1;
        end else begin
            chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
            chk("idle_lane_valid", 32'(bus.lane_valid), 32'd0);
            chk("idle_data", 32'(bus.data_out), 32'(last_data));
            chk("idle_sel", 32'(bus.sel_out), 32'(last_sel));
            chk("idle_count", 32'(bus.xfer_count), 32'(cnt_m));
        end
    end

    task automatic send(input logic [7:0] d, input logic m, input logic [1:0] ms);
        int unsigned k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) begin
            chk("send_timeout", 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.in_data  = d;
        bus.mode     = m;
        bus.man_sel  = ms;
        bus.in_valid = 1'b1;
        @(posedge clk);
        q.push_back('{data: d, sel: m ? ms : rr_m});
        if (!m) rr_m = rr_m + 2'd1;
        #1;
        bus.in_valid = 1'b0;
        bus.mode     = 1'($urandom);
        bus.man_sel  = 2'($urandom);
        bus.in_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int unsigned k = 0;
        @(negedge clk);
        while ((q.size() != 0 || bus.busy || mon_active) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_busy();
        int unsigned k = 0;
        @(negedge clk);
        while (!bus.busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.busy) chk("busy_timeout", 32'(bus.busy), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rr_words [5];
        rr_words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.mode       = 1'b0;
        bus.man_sel    = 2'd0;
        bus.lane_ready = 4'hF;
        repeat (3) @(negedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_count", 32'(bus.xfer_count), 32'd0);

        // round-robin with all lanes ready: lanes 0,1,2,3,0 and count wraps 1,2,3,0,1
        rdy_mode = 1;
        foreach (rr_words[i]) send(rr_words[i], 1'b0, 2'd0);
        wait_idle();
        chk("rr_count_wrap", 32'(bus.xfer_count), 32'd1);
        chk("rr_last_sel", 32'(bus.sel_out), 32'd0);

        // backpressure on lane 1 while other lanes stay ready
        rdy_force = 4'b1101;
        rdy_mode  = 2;
        send(8'h5A, 1'b0, 2'd0);
        repeat (10) @(negedge clk);
        chk("bp_lane_valid", 32'(bus.lane_valid), 32'b0010);
        chk("bp_data", 32'(bus.data_out), 32'h5A);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        rdy_mode = 1;
        wait_idle();
        chk("bp_count", 32'(bus.xfer_count), 32'd2);
        send(8'h66, 1'b0, 2'd3);
        wait_busy();
        chk("bp_next_rr_sel", 32'(bus.sel_out), 32'd2);
        wait_idle();

        // manual lane 2 leaves rr_ptr at 3
        for (int i = 0; i < 3; i++) send(8'(8'h70 + i), 1'b1, 2'd2);
        wait_idle();
        chk("man_sel_out", 32'(bus.sel_out), 32'd2);
        send(8'h99, 1'b0, 2'd1);
        wait_busy();
        chk("man_resume_rr", 32'(bus.sel_out), 32'd3);
        wait_idle();

        // random traffic with random lane acks and switch changes mid-HOLD
        rdy_mode = 0;
        for (int i = 0; i < 40; i++) send(8'($urandom), 1'($urandom), 2'($urandom));
        wait_idle();

        // reset mid-HOLD drops the word
        rdy_mode = 1;
        send(8'hC7, 1'b1, 2'd3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_sel", 32'(bus.sel_out), 32'd0);
        chk("rst_lane_valid", 32'(bus.lane_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_count", 32'(bus.xfer_count), 32'd0);
        q.delete();
        rr_m = 2'd0;
        repeat (2) @(negedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        send(8'h11, 1'b0, 2'd2);
        wait_busy();
        chk("post_rst_rr_sel", 32'(bus.sel_out), 32'd0);
        rdy_mode = 0;
        for (int i = 0; i < 10; i++) send(8'($urandom), 1'($urandom), 2'($urandom));
        rdy_mode = 1;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
